ecc_wr_encoder_pipe: RTL and testbench

Write-path ECC stage for the 39/32 SECDED-protected data memories. Accepts 32-bit write requests over valid/ready, appends 7 Hsiao check bits, and presents registered 39-bit codewords to the memory port. Sits between the LSU/DMA write arbiter and the SRAM macro. The matching read-side decoder checks its output. Also contains an init sequencer that writes a valid codeword to every memory word after reset, or on request.

---
 rtl/ecc_secded_pkg.sv | 33 +++
 rtl/secded_39_32_enc.sv | 17 +
 rtl/ecc_wr_encoder_pipe.sv | 171 +++++++++++++++++
 tb/tb_ecc_wr_encoder_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pkg.sv
// Shared constants, encode function and init-sequencer states for the 39/32 Hsiao SECDED write path.
package ecc_secded_pkg;

    localparam int SecdedDataW = 32;
    localparam int SecdedCodeW = 39;
    localparam int SecdedChkW  = SecdedCodeW - SecdedDataW;

    // Entry k selects the data bits covered by check bit k; each data bit is covered by exactly three.
    localparam logic [SecdedChkW-1:0][SecdedDataW-1:0] SecdedMask = {
        32'h93360FA2,
        32'h047D6456,
        32'h4D12083D,
        32'h72C05A53,
        32'h8CC1B6A1,
        32'hEA2AB148,
        32'h318DC18C
    };

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        INIT
    } init_state_e;

    function automatic logic [SecdedCodeW-1:0] secded_39_32_encode(input logic [SecdedDataW-1:0] data);
        logic [SecdedChkW-1:0] chk;
        for (int k = 0; k < SecdedChkW; k++) begin
            chk[k] = ^(data & SecdedMask[k]);
        end
        return {chk, data};
    endfunction

endpackage

// File: rtl/secded_39_32_enc.sv
// Combinational Hsiao 39/32 encoder: codeword = {check[6:0], data[31:0]}.
module secded_39_32_enc
    import ecc_secded_pkg::*;
(
    input  logic [SecdedDataW-1:0] data_i,
    output logic [SecdedCodeW-1:0] codeword_o
);

    logic [SecdedChkW-1:0] chk;

    for (genvar gi = 0; gi < SecdedChkW; gi++) begin : g_chk
        assign chk[gi] = ^(data_i & SecdedMask[gi]);
    end

    assign codeword_o = {chk, data_i};

endmodule

// File: rtl/ecc_wr_encoder_pipe.sv
// Write-path SECDED encoder: registered output stage, 1-entry skid and post-reset init sweep.
// Define ECC_ERR_INJECT_EN to add inj_mask_i, XORed into every codeword loaded into the output stage.
module ecc_wr_encoder_pipe
    import ecc_secded_pkg::*;
#(
    parameter int          AddrWidth = 10,
    parameter int          Depth     = 1024,
    parameter logic [31:0] InitData  = 32'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [SecdedDataW-1:0] req_data_i,
    input  logic                   init_req_i,
    output logic                   init_busy_o,
    output logic                   init_done_o,
    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [SecdedCodeW-1:0] mem_wdata_o
`ifdef ECC_ERR_INJECT_EN
    ,
    input  logic [SecdedCodeW-1:0] inj_mask_i
`endif
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    init_state_e            state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [AddrWidth-1:0]   out_addr_q, out_addr_d;
    logic [SecdedCodeW-1:0] out_data_q, out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [AddrWidth-1:0]   skid_addr_q, skid_addr_d;
    logic [SecdedDataW-1:0] skid_data_q, skid_data_d;
    logic [AddrWidth-1:0]   cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;

    logic [SecdedDataW-1:0] enc_data;
    logic [SecdedCodeW-1:0] enc_cw;
    logic [SecdedCodeW-1:0] load_cw;
    logic                   accept;
    logic                   out_free;

    assign accept   = req_valid_i & ready_q;
    assign out_free = ~out_valid_q | mem_ready_i;

    // Single encoder: the skid always has priority over a fresh request when both could load.
    always_comb begin
        enc_data = req_data_i;
        if (state_q == INIT) begin
            enc_data = InitData;
        end else if (skid_valid_q) begin
            enc_data = skid_data_q;
        end
    end

    secded_39_32_enc u_enc (
        .data_i     (enc_data),
        .codeword_o (enc_cw)
    );

`ifdef ECC_ERR_INJECT_EN
    assign load_cw = enc_cw ^ inj_mask_i;
`else
    assign load_cw = enc_cw;
`endif

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE, FLUSH: begin
                if (out_free) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_addr_d   = skid_addr_q;
                        out_data_d   = load_cw;
                        skid_valid_d = 1'b0;
                    end else if (accept) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = req_addr_i;
                        out_data_d  = load_cw;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_addr_d  = req_addr_i;
                    skid_data_d  = req_data_i;
                end

                if (state_q == IDLE && init_req_i) begin
                    state_d = FLUSH;
                end else if (state_q == FLUSH && !skid_valid_q && out_free) begin
                    state_d = INIT;
                end
            end

            INIT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = cnt_q;
                    out_data_d  = load_cw;
                end else if (mem_ready_i) begin
                    if (cnt_q == LastAddr) begin
                        out_valid_d = 1'b0;
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d      = cnt_q + AddrWidth'(1);
                        out_addr_d = cnt_q + AddrWidth'(1);
                        out_data_d = load_cw;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) && !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    assign req_ready_o = ready_q;
    assign init_busy_o = (state_q != IDLE);
    assign init_done_o = done_q;
    assign mem_valid_o = out_valid_q;
    assign mem_addr_o  = out_addr_q;
    assign mem_wdata_o = out_data_q;

endmodule

// File: tb/tb_ecc_wr_encoder_pipe.sv
// Bench for ecc_wr_encoder_pipe: expected-write queue model checked every cycle plus directed literal checks.
module tb_ecc_wr_encoder_pipe;

    localparam int          AW        = 10;
    localparam int          DEPTH     = 8;
    localparam logic [31:0] INIT_DATA = 32'h0000_0001;
    localparam bit [31:0]   TB_MASK [0:6] = '{32'h318DC18C, 32'hEA2AB148, 32'h8CC1B6A1, 32'h72C05A53,
                                              32'h4D12083D, 32'h047D6456, 32'h93360FA2};

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_data_i = '0;
    logic          init_req_i = 1'b0;
    logic          init_busy_o;
    logic          init_done_o;
    logic          mem_valid_o;
    logic          mem_ready_i = 1'b1;
    logic [AW-1:0] mem_addr_o;
    logic [38:0]   mem_wdata_o;
    logic [38:0]   inj_mask_tb = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ecc_wr_encoder_pipe #(
        .AddrWidth (AW),
        .Depth     (DEPTH),
        .InitData  (INIT_DATA)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .init_req_i  (init_req_i),
        .init_busy_o (init_busy_o),
        .init_done_o (init_done_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
`ifdef ECC_ERR_INJECT_EN
        ,
        .inj_mask_i  (inj_mask_tb)
`endif
    );

    // Check bit k is the parity of the data bits selected by mask k.
    function automatic logic [38:0] model_enc(input logic [31:0] d);
        logic [6:0] c;
        for (int k = 0; k < 7; k++) begin
            c[k] = ($countones(d & TB_MASK[k]) % 2) == 1;
        end
        return {c, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [38:0]   cw;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    bit            model_on   = 1'b0;
    bit            rst_seen   = 1'b0;
    bit            model_busy = 1'b0;
    bit            done_exp   = 1'b0;
    bit            stall_prev = 1'b0;
    logic [AW-1:0] held_addr  = '0;
    logic [38:0]   held_cw    = '0;

    // Everything sampled here is stable for the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        bit   busy_now;
        if (model_on) begin
            if (rst_seen) begin
                chk("rst_mem_valid", 64'(mem_valid_o), 64'(0));
                chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
                chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
                chk("rst_req_ready", 64'(req_ready_o), 64'(0));
            end else if (stall_prev) begin
                chk("stall_valid", 64'(mem_valid_o), 64'(1));
                chk("stall_addr", 64'(mem_addr_o), 64'(held_addr));
                chk("stall_wdata", 64'(mem_wdata_o), 64'(held_cw));
            end
            chk("init_done", 64'(init_done_o), 64'(done_exp));
            chk("init_busy", 64'(init_busy_o), 64'(model_busy));
            if (model_busy) chk("ready_while_busy", 64'(req_ready_o), 64'(0));
        end
        if (rst_i) begin
            exp_q.delete();
            model_busy = 1'b0;
            done_exp   = 1'b0;
            stall_prev = 1'b0;
            rst_seen   = 1'b1;
            model_on   = 1'b1;
        end else if (model_on) begin
            rst_seen = 1'b0;
            done_exp = 1'b0;
            busy_now = model_busy;
            if (mem_valid_o && mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 64'(mem_addr_o), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(mem_addr_o), 64'(e.addr));
                    chk("write_data", 64'(mem_wdata_o), 64'(e.cw));
                    if (e.last) begin
                        done_exp   = 1'b1;
                        model_busy = 1'b0;
                    end
                end
            end
            stall_prev = mem_valid_o && !mem_ready_i;
            held_addr  = mem_addr_o;
            held_cw    = mem_wdata_o;
            if (req_valid_i && req_ready_o) begin
                exp_q.push_back('{addr: req_addr_i, cw: model_enc(req_data_i) ^ inj_mask_tb, last: 1'b0});
            end
            if (init_req_i && !busy_now) begin
                model_busy = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    exp_q.push_back('{addr: AW'(i), cw: model_enc(INIT_DATA) ^ inj_mask_tb,
                                      last: (i == DEPTH - 1)});
                end
            end
        end
    end

    // Leaves req_valid_i asserted so consecutive calls stream back to back.
    task automatic send(input logic [AW-1:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready_o;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 64'(ok), 64'(1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  dones;
        bit  found;

        chk("model_pin_one", 64'(model_enc(32'h0000_0001)), 64'h1C_0000_0001);
        chk("model_pin_ones", 64'(model_enc(32'hFFFF_FFFF)), 64'h41_FFFF_FFFF);

        cycles(3);
        rst_i = 1'b0;

        // Basic and pattern encodes
        send(10'd5, 32'h0000_0001);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("basic_valid", 64'(mem_valid_o), 64'(1));
        chk("basic_addr", 64'(mem_addr_o), 64'(5));
        chk("basic_wdata", 64'(mem_wdata_o), 64'h1C_0000_0001);
        cycles(1);
        send(10'd7, 32'hFFFF_FFFF);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("ones_wdata", 64'(mem_wdata_o), 64'h41_FFFF_FFFF);
        cycles(1);
        send(10'd9, 32'h0);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("zero_addr", 64'(mem_addr_o), 64'(9));
        chk("zero_wdata", 64'(mem_wdata_o), 64'h0);
        cycles(2);

        // Backpressure: three stalled edges in the middle of a 4-write stream
        send(10'h100, 32'hDEAD_BEEF);
        send(10'h101, 32'h1357_9BDF);
        mem_ready_i = 1'b0;
        send(10'h102, 32'h2468_ACE0);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("skid_full_ready", 64'(req_ready_o), 64'(0));
        chk("stall_head_addr", 64'(mem_addr_o), 64'h101);
        cycles(2);
        mem_ready_i = 1'b1;
        send(10'h103, 32'h8000_0000);
        req_valid_i = 1'b0;
        cycles(4);

        // Init sweep with two writes in flight and intermittent backpressure
        send(10'd20, 32'hA5A5_0001);
        init_req_i = 1'b1;
        send(10'd21, 32'h0BAD_F00D);
        init_req_i  = 1'b0;
        req_valid_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (init_done_o) dones++;
            @(posedge clk);
            #1;
            mem_ready_i = (c % 5) != 2;
        end
        mem_ready_i = 1'b1;
        chk("init_done_count", 64'(dones), 64'(1));
        chk("init_idle_after", 64'(init_busy_o), 64'(0));

        // Reset in the middle of a sweep while address 3 is presented
        init_req_i = 1'b1;
        cycles(1);
        init_req_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(posedge clk);
            #1;
            found = mem_valid_o && (mem_addr_o == 10'd3) && init_busy_o;
        end
        chk("sweep_reached_3", 64'(found), 64'(1));
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(init_busy_o), 64'(0));
        chk("midrst_done", 64'(init_done_o), 64'(0));
        chk("midrst_valid", 64'(mem_valid_o), 64'(0));
        cycles(10);

`ifdef ECC_ERR_INJECT_EN
        inj_mask_tb = 39'h1;
        send(10'd3, 32'h0);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("inject_wdata", 64'(mem_wdata_o), 64'h1);
        cycles(1);
        inj_mask_tb = '0;
`endif

        send(10'h3FF, 32'h1234_5678);
        req_valid_i = 1'b0;
        cycles(5);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
